// File: rtl/rv_ahbl_2m_arbiter.sv
// rtl/rv_ahbl_2m_arbiter.sv - two-master to one-slave AHB-Lite arbiter
// Losing masters are stalled and their accepted address phase is held in a skid register.
module rv_ahbl_2m_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b0
) (
  input  logic              cpu_clk,
  input  logic              pad_cpu_rst_b,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hlock,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hlock,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [2:0]        s_hburst,
  output logic [3:0]        s_hprot,
  output logic              s_hmastlock,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hready,
  input  logic              s_hresp
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } addr_phase_t;

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_e;

  addr_phase_t live0, live1, hold0, hold1, src0, src1, src_sel, src_gcur;
  owner_e      downer;
  logic        pend0, pend1, gcur, last, lockh;
  logic        req0, req1, req_sel, sel, issue, capture0, capture1;

  assign live0 = '{addr: m0_haddr, trans: m0_htrans, write: m0_hwrite, size: m0_hsize,
                   burst: m0_hburst, prot: m0_hprot, lock: m0_hlock};
  assign live1 = '{addr: m1_haddr, trans: m1_htrans, write: m1_hwrite, size: m1_hsize,
                   burst: m1_hburst, prot: m1_hprot, lock: m1_hlock};

  assign src0     = pend0 ? hold0 : live0;
  assign src1     = pend1 ? hold1 : live1;
  assign src_gcur = gcur ? src1 : src0;

  always_comb begin
    m0_hready = 1'b1;
    m0_hresp  = 1'b0;
    m1_hready = 1'b1;
    m1_hresp  = 1'b0;
    if (downer == OWN_M0) begin
      m0_hready = s_hready;
      m0_hresp  = s_hresp;
    end else if (pend0) begin
      m0_hready = 1'b0;
    end
    if (downer == OWN_M1) begin
      m1_hready = s_hready;
      m1_hresp  = s_hresp;
    end else if (pend1) begin
      m1_hready = 1'b0;
    end
  end

  // Reset masks requests so the slave port goes idle immediately, not at the next edge.
  assign req0 = pad_cpu_rst_b & (pend0 | (m0_hready & m0_htrans[1]));
  assign req1 = pad_cpu_rst_b & (pend1 | (m1_hready & m1_htrans[1]));

  always_comb begin
    sel = gcur;
    if (lockh || (src_gcur.trans == 2'b11)) sel = gcur;
    else if (req0 && req1)                  sel = RR_EN ? ~last : 1'b0;
    else if (req0)                          sel = 1'b0;
    else if (req1)                          sel = 1'b1;
  end

  assign src_sel  = sel ? src1 : src0;
  assign req_sel  = sel ? req1 : req0;
  assign issue    = s_hready & req_sel;
  assign capture0 = pad_cpu_rst_b & m0_hready & m0_htrans[1] & ~(issue & ~sel & ~pend0);
  assign capture1 = pad_cpu_rst_b & m1_hready & m1_htrans[1] & ~(issue &  sel & ~pend1);

  assign s_haddr     = pad_cpu_rst_b ? src_sel.addr  : '0;
  assign s_hwrite    = pad_cpu_rst_b ? src_sel.write : 1'b0;
  assign s_hsize     = pad_cpu_rst_b ? src_sel.size  : 3'd0;
  assign s_hburst    = pad_cpu_rst_b ? src_sel.burst : 3'd0;
  assign s_hprot     = pad_cpu_rst_b ? src_sel.prot  : 4'd0;
  assign s_htrans    = req_sel ? src_sel.trans : 2'b00;
  assign s_hmastlock = req_sel & src_sel.lock;

  always_comb begin
    s_hwdata = '0;
    if (downer == OWN_M0)      s_hwdata = m0_hwdata;
    else if (downer == OWN_M1) s_hwdata = m1_hwdata;
  end

  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      pend0  <= 1'b0;
      pend1  <= 1'b0;
      hold0  <= '0;
      hold1  <= '0;
      downer <= OWN_NONE;
      gcur   <= 1'b0;
      lockh  <= 1'b0;
      last   <= 1'b1;
    end else begin
      if (s_hready) begin
        if (issue) begin
          downer <= sel ? OWN_M1 : OWN_M0;
          gcur   <= sel;
          last   <= sel;
          lockh  <= src_sel.lock;
        end else begin
          downer <= OWN_NONE;
        end
      end
      if (capture0) begin
        pend0 <= 1'b1;
        hold0 <= live0;
      end else if (issue && !sel) begin
        pend0 <= 1'b0;
      end
      if (capture1) begin
        pend1 <= 1'b1;
        hold1 <= live1;
      end else if (issue && sel) begin
        pend1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_ahbl_2m_arbiter.sv
// tb/tb_rv_ahbl_2m_arbiter.sv - directed bench for rv_ahbl_2m_arbiter
// Instance a is fixed priority, instance b is round-robin; both share all inputs.
module tb_rv_ahbl_2m_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, s_hrdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, m0_hlock, m1_hlock, s_hready, s_hresp;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;

  logic [31:0] a_m0_hrdata, a_m1_hrdata, a_s_haddr, a_s_hwdata;
  logic        a_m0_hready, a_m0_hresp, a_m1_hready, a_m1_hresp, a_s_hwrite, a_s_hmastlock;
  logic [1:0]  a_s_htrans;
  logic [2:0]  a_s_hsize, a_s_hburst;
  logic [3:0]  a_s_hprot;
  logic [31:0] b_m0_hrdata, b_m1_hrdata, b_s_haddr, b_s_hwdata;
  logic        b_m0_hready, b_m0_hresp, b_m1_hready, b_m1_hresp, b_s_hwrite, b_s_hmastlock;
  logic [1:0]  b_s_htrans;
  logic [2:0]  b_s_hsize, b_s_hburst;
  logic [3:0]  b_s_hprot;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_ahbl_2m_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_a (
    .cpu_clk(clk), .pad_cpu_rst_b(rst_n),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hlock(m0_hlock), .m0_hwdata(m0_hwdata),
    .m0_hrdata(a_m0_hrdata), .m0_hready(a_m0_hready), .m0_hresp(a_m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hlock(m1_hlock), .m1_hwdata(m1_hwdata),
    .m1_hrdata(a_m1_hrdata), .m1_hready(a_m1_hready), .m1_hresp(a_m1_hresp),
    .s_haddr(a_s_haddr), .s_htrans(a_s_htrans), .s_hwrite(a_s_hwrite), .s_hsize(a_s_hsize),
    .s_hburst(a_s_hburst), .s_hprot(a_s_hprot), .s_hmastlock(a_s_hmastlock), .s_hwdata(a_s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  rv_ahbl_2m_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_b (
    .cpu_clk(clk), .pad_cpu_rst_b(rst_n),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hlock(m0_hlock), .m0_hwdata(m0_hwdata),
    .m0_hrdata(b_m0_hrdata), .m0_hready(b_m0_hready), .m0_hresp(b_m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hlock(m1_hlock), .m1_hwdata(m1_hwdata),
    .m1_hrdata(b_m1_hrdata), .m1_hready(b_m1_hready), .m1_hresp(b_m1_hresp),
    .s_haddr(b_s_haddr), .s_htrans(b_s_htrans), .s_hwrite(b_s_hwrite), .s_hsize(b_s_hsize),
    .s_hburst(b_s_hburst), .s_hprot(b_s_hprot), .s_hmastlock(b_s_hmastlock), .s_hwdata(b_s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_htrans = 2'd0; m0_haddr = '0; m0_hwrite = 1'b0; m0_hlock = 1'b0;
    m1_htrans = 2'd0; m1_haddr = '0; m1_hwrite = 1'b0; m1_hlock = 1'b0;
    m0_hsize = 3'd2; m1_hsize = 3'd2; m0_hburst = 3'd0; m1_hburst = 3'd0;
    m0_hprot = 4'd3; m1_hprot = 4'd3; m0_hwdata = '0; m1_hwdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_masters();
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    m0_htrans = 2'd2; m0_haddr = 32'h1234_5678; m0_hlock = 1'b1;
    #2;
    checks++; if (a_s_htrans !== 2'd0) begin failures++; $display("FAIL rst_htrans got=%0h exp=0", a_s_htrans); end
    checks++; if (a_s_haddr !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%0h exp=0", a_s_haddr); end
    checks++; if (a_s_hmastlock !== 1'b0) begin failures++; $display("FAIL rst_mastlock got=%0b exp=0", a_s_hmastlock); end
    checks++; if ({a_m0_hready, a_m1_hready} !== 2'b11) begin failures++; $display("FAIL rst_hready got=%0b exp=11", {a_m0_hready, a_m1_hready}); end
    checks++; if ({a_m0_hresp, a_m1_hresp} !== 2'b00) begin failures++; $display("FAIL rst_hresp got=%0b exp=00", {a_m0_hresp, a_m1_hresp}); end
    idle_masters();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    step();
    m0_htrans = 2'd2; m0_haddr = 32'h2000_0000; m0_hwrite = 1'b0;
    #2;
    checks++; if (a_s_htrans !== 2'd2) begin failures++; $display("FAIL t1_htrans got=%0h exp=2", a_s_htrans); end
    checks++; if (a_s_haddr !== 32'h2000_0000) begin failures++; $display("FAIL t1_haddr got=%0h exp=20000000", a_s_haddr); end
    checks++; if (a_m1_hready !== 1'b1) begin failures++; $display("FAIL t1_m1_ready0 got=%0b exp=1", a_m1_hready); end
    step();
    idle_masters();
    s_hrdata = 32'hDEAD_BEEF;
    #2;
    checks++; if (a_m0_hready !== 1'b1) begin failures++; $display("FAIL t1_m0_ready got=%0b exp=1", a_m0_hready); end
    checks++; if (a_m0_hrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t1_rdata got=%0h exp=deadbeef", a_m0_hrdata); end
    checks++; if (a_m1_hready !== 1'b1) begin failures++; $display("FAIL t1_m1_ready1 got=%0b exp=1", a_m1_hready); end
  endtask

  task automatic test_contention();
    step();
    m0_htrans = 2'd2; m0_haddr = 32'h4000_0010; m0_hwrite = 1'b1;
    m1_htrans = 2'd2; m1_haddr = 32'h0000_0100; m1_hwrite = 1'b0;
    #2;
    checks++; if (a_s_haddr !== 32'h4000_0010) begin failures++; $display("FAIL t2_c0_haddr got=%0h exp=40000010", a_s_haddr); end
    checks++; if (a_s_hwrite !== 1'b1) begin failures++; $display("FAIL t2_c0_hwrite got=%0b exp=1", a_s_hwrite); end
    checks++; if (a_m1_hready !== 1'b1) begin failures++; $display("FAIL t2_c0_m1_ready got=%0b exp=1", a_m1_hready); end
    step();
    idle_masters();
    m0_hwdata = 32'h1111_2222;
    #2;
    checks++; if (a_s_htrans !== 2'd2) begin failures++; $display("FAIL t2_c1_htrans got=%0h exp=2", a_s_htrans); end
    checks++; if (a_s_haddr !== 32'h0000_0100) begin failures++; $display("FAIL t2_c1_haddr got=%0h exp=100", a_s_haddr); end
    checks++; if (a_s_hwrite !== 1'b0) begin failures++; $display("FAIL t2_c1_hwrite got=%0b exp=0", a_s_hwrite); end
    checks++; if (a_m1_hready !== 1'b0) begin failures++; $display("FAIL t2_c1_m1_ready got=%0b exp=0", a_m1_hready); end
    checks++; if (a_s_hwdata !== 32'h1111_2222) begin failures++; $display("FAIL t2_c1_hwdata got=%0h exp=11112222", a_s_hwdata); end
    step();
    m0_hwdata = '0;
    s_hrdata = 32'hCAFE_0001;
    #2;
    checks++; if (a_m1_hready !== 1'b1) begin failures++; $display("FAIL t2_c2_m1_ready got=%0b exp=1", a_m1_hready); end
    checks++; if (a_m1_hrdata !== 32'hCAFE_0001) begin failures++; $display("FAIL t2_c2_rdata got=%0h exp=cafe0001", a_m1_hrdata); end
    checks++; if (a_s_htrans !== 2'd0) begin failures++; $display("FAIL t2_c2_htrans got=%0h exp=0", a_s_htrans); end
  endtask

  task automatic test_rr_back_to_back();
    logic [31:0] addr0, addr1, exp_addr;
    do_reset();
    addr0 = 32'h0000_1000;
    addr1 = 32'h0000_8000;
    for (int k = 0; k < 8; k++) begin
      step();
      m0_htrans = 2'd2; m0_haddr = addr0;
      m1_htrans = 2'd2; m1_haddr = addr1;
      #2;
      exp_addr = (k % 2 == 0) ? 32'h0000_1000 + 32'(k / 2) * 4 : 32'h0000_8000 + 32'(k / 2) * 4;
      checks++; if (b_s_haddr !== exp_addr) begin failures++; $display("FAIL t3_haddr[%0d] got=%0h exp=%0h", k, b_s_haddr, exp_addr); end
      checks++; if (b_s_htrans !== 2'd2) begin failures++; $display("FAIL t3_htrans[%0d] got=%0h exp=2", k, b_s_htrans); end
      if (b_m0_hready) addr0 = addr0 + 4;
      if (b_m1_hready) addr1 = addr1 + 4;
    end
    step();
    idle_masters();
  endtask

  task automatic test_lock();
    do_reset();
    step();
    m1_htrans = 2'd2; m1_haddr = 32'h300; m1_hlock = 1'b1;
    #2;
    checks++; if (a_s_haddr !== 32'h300) begin failures++; $display("FAIL t4_c0_haddr got=%0h exp=300", a_s_haddr); end
    checks++; if (a_s_hmastlock !== 1'b1) begin failures++; $display("FAIL t4_c0_mastlock got=%0b exp=1", a_s_hmastlock); end
    step();
    idle_masters();
    m0_htrans = 2'd2; m0_haddr = 32'h500;
    #2;
    checks++; if (a_s_htrans !== 2'd0) begin failures++; $display("FAIL t4_c1_htrans got=%0h exp=0", a_s_htrans); end
    checks++; if (a_s_hmastlock !== 1'b0) begin failures++; $display("FAIL t4_c1_mastlock got=%0b exp=0", a_s_hmastlock); end
    step();
    idle_masters();
    m1_htrans = 2'd2; m1_haddr = 32'h304; m1_hlock = 1'b0;
    #2;
    checks++; if (a_m0_hready !== 1'b0) begin failures++; $display("FAIL t4_c2_m0_ready got=%0b exp=0", a_m0_hready); end
    checks++; if (a_s_haddr !== 32'h304) begin failures++; $display("FAIL t4_c2_haddr got=%0h exp=304", a_s_haddr); end
    checks++; if (a_s_hmastlock !== 1'b0) begin failures++; $display("FAIL t4_c2_mastlock got=%0b exp=0", a_s_hmastlock); end
    step();
    idle_masters();
    #2;
    checks++; if (a_s_haddr !== 32'h500 || a_s_htrans !== 2'd2) begin failures++; $display("FAIL t4_c3_m0_issue got=%0h/%0h exp=500/2", a_s_haddr, a_s_htrans); end
    checks++; if (a_m0_hready !== 1'b0) begin failures++; $display("FAIL t4_c3_m0_ready got=%0b exp=0", a_m0_hready); end
    step();
    #2;
    checks++; if (a_m0_hready !== 1'b1) begin failures++; $display("FAIL t4_c4_m0_ready got=%0b exp=1", a_m0_hready); end
  endtask

  task automatic test_error();
    logic [3:0] rdy_tab, rsp_tab;
    rdy_tab = 4'b1000;
    rsp_tab = 4'b1100;
    do_reset();
    step();
    m0_htrans = 2'd2; m0_haddr = 32'h10;
    m1_htrans = 2'd2; m1_haddr = 32'h20;
    #2;
    checks++; if (a_s_haddr !== 32'h10) begin failures++; $display("FAIL t5_c0_haddr got=%0h exp=10", a_s_haddr); end
    step();
    idle_masters();
    #2;
    checks++; if (a_s_haddr !== 32'h20) begin failures++; $display("FAIL t5_c1_haddr got=%0h exp=20", a_s_haddr); end
    checks++; if ({a_m1_hready, a_m1_hresp} !== 2'b00) begin failures++; $display("FAIL t5_c1_m1 got=%0b exp=00", {a_m1_hready, a_m1_hresp}); end
    for (int k = 0; k < 4; k++) begin
      step();
      s_hready = rdy_tab[k];
      s_hresp  = rsp_tab[k];
      #2;
      checks++; if ({a_m1_hready, a_m1_hresp} !== {rdy_tab[k], rsp_tab[k]}) begin failures++; $display("FAIL t5_m1[%0d] got=%0b exp=%0b", k, {a_m1_hready, a_m1_hresp}, {rdy_tab[k], rsp_tab[k]}); end
      checks++; if ({a_m0_hready, a_m0_hresp} !== 2'b10) begin failures++; $display("FAIL t5_m0[%0d] got=%0b exp=10", k, {a_m0_hready, a_m0_hresp}); end
    end
    step();
    s_hready = 1'b1; s_hresp = 1'b0;
    #2;
    checks++; if ({a_m1_hready, a_m1_hresp} !== 2'b10) begin failures++; $display("FAIL t5_after got=%0b exp=10", {a_m1_hready, a_m1_hresp}); end
    checks++; if (a_s_htrans !== 2'd0) begin failures++; $display("FAIL t5_after_htrans got=%0h exp=0", a_s_htrans); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    m0_htrans = 2'd2; m0_haddr = 32'h40;
    m1_htrans = 2'd2; m1_haddr = 32'h80;
    step();
    idle_masters();
    s_hready = 1'b0;
    #2;
    checks++; if (a_m1_hready !== 1'b0) begin failures++; $display("FAIL t6_pre_m1_ready got=%0b exp=0", a_m1_hready); end
    checks++; if (a_s_htrans !== 2'd2 || a_s_haddr !== 32'h80) begin failures++; $display("FAIL t6_pre_issue got=%0h/%0h exp=2/80", a_s_htrans, a_s_haddr); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_s_htrans !== 2'd0) begin failures++; $display("FAIL t6_rst_htrans got=%0h exp=0", a_s_htrans); end
    checks++; if ({a_m0_hready, a_m1_hready} !== 2'b11) begin failures++; $display("FAIL t6_rst_ready got=%0b exp=11", {a_m0_hready, a_m1_hready}); end
    step();
    step();
    s_hready = 1'b1;
    rst_n = 1'b1;
    #2;
    checks++; if (a_s_htrans !== 2'd0) begin failures++; $display("FAIL t6_rel0_htrans got=%0h exp=0", a_s_htrans); end
    step();
    #2;
    checks++; if (a_s_htrans !== 2'd0) begin failures++; $display("FAIL t6_rel1_htrans got=%0h exp=0", a_s_htrans); end
    checks++; if (a_m1_hready !== 1'b1) begin failures++; $display("FAIL t6_rel1_m1_ready got=%0b exp=1", a_m1_hready); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_rr_back_to_back();
    test_lock();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
